noise_generator_mc: RTL and testbench

//  Parametrised multi-channel noise source; successor to the single-channel noise_generator2.
//  Per channel: Galois LFSR -> uniform signed sample -> sliding sum of SUM_TERMS samples (CLT Gaussian approx).

---
 rtl/noise_generator_mc.sv | 115 +++++++++++
 tb/tb_noise_generator_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/noise_generator_mc.sv
// Multi-channel noise source: per-channel Galois LFSR, uniform sample, sliding-window sum (CLT Gaussian).
// Optional peak-magnitude tracker is enabled by defining NOISE_PEAK_EN.
module noise_generator_mc #(
  parameter int          WIDTH     = 16,
  parameter int          CHANNELS  = 2,
  parameter int          LFSR_W    = 32,
  parameter int          SUM_TERMS = 4,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_enable,
  input  logic                      load,
  input  logic [LFSR_W-1:0]         seed_in,
  input  logic                      mode,
  input  logic [3:0]                atten,
`ifdef NOISE_PEAK_EN
  input  logic                      peak_clr,
  output logic [CHANNELS*WIDTH-1:0] peak,
`endif
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_valid
);

  localparam int LOG2  = $clog2(SUM_TERMS);
  localparam int ACC_W = WIDTH + LOG2;
  localparam int CNT_W = $clog2(SUM_TERMS + 2);
  localparam logic [LFSR_W-1:0] MASK = LFSR_W'(32'h8020_0003);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SUM_TERMS + 1);

  logic        [LFSR_W-1:0] lfsr     [CHANNELS];
  logic        [LFSR_W-1:0] lfsr_nxt [CHANNELS];
  logic signed [WIDTH-1:0]  win      [CHANNELS][SUM_TERMS];
  logic signed [WIDTH-1:0]  samp     [CHANNELS];
  logic signed [WIDTH-1:0]  out_nxt  [CHANNELS];
  logic signed [ACC_W-1:0]  acc      [CHANNELS];
  logic signed [ACC_W-1:0]  acc_nxt  [CHANNELS];
  logic        [CNT_W-1:0]  cnt;

  // Channels share one base seed; a golden-ratio multiple decorrelates them, zero is remapped to avoid lockup.
  function automatic logic [LFSR_W-1:0] derive(input logic [LFSR_W-1:0] s, input int c);
    logic [LFSR_W-1:0] d;
    d = s ^ LFSR_W'(LFSR_W'(c) * 32'h9E37_79B9);
    if (d == '0) d = LFSR_W'(1);
    return d;
  endfunction

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      samp[c]     = lfsr[c][LFSR_W-1 -: WIDTH];
      lfsr_nxt[c] = (lfsr[c] >> 1) ^ (lfsr[c][0] ? MASK : '0);
      acc_nxt[c]  = acc[c] + ACC_W'(samp[c]) - ACC_W'(win[c][SUM_TERMS-1]);
      if (mode) out_nxt[c] = samp[c] >>> atten;
      else      out_nxt[c] = WIDTH'(acc[c] >>> (LOG2 + int'(atten)));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        lfsr[c] <= derive(SEED, c);
        acc[c]  <= '0;
        for (int k = 0; k < SUM_TERMS; k++) win[c][k] <= '0;
      end
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      for (int c = 0; c < CHANNELS; c++) begin
        lfsr[c] <= derive(seed_in, c);
        acc[c]  <= '0;
        for (int k = 0; k < SUM_TERMS; k++) win[c][k] <= '0;
      end
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (clk_enable) begin
      for (int c = 0; c < CHANNELS; c++) begin
        lfsr[c] <= lfsr_nxt[c];
        acc[c]  <= acc_nxt[c];
        for (int k = SUM_TERMS - 1; k > 0; k--) win[c][k] <= win[c][k-1];
        win[c][0] <= samp[c];
        out[c*WIDTH +: WIDTH] <= out_nxt[c];
      end
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      // Counter reaches SUM_TERMS+1 on this edge, so the window held a full set when acc was sampled.
      if (cnt >= CNT_W'(SUM_TERMS)) out_valid <= 1'b1;
    end
  end

`ifdef NOISE_PEAK_EN
  logic [WIDTH-1:0] mag [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      mag[c] = out[c*WIDTH +: WIDTH];
      if (out[c*WIDTH + WIDTH - 1]) begin
        if (out[c*WIDTH +: WIDTH] == {1'b1, {(WIDTH-1){1'b0}}}) mag[c] = {1'b0, {(WIDTH-1){1'b1}}};
        else                                                   mag[c] = -out[c*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak <= '0;
    end else if (peak_clr || load) begin
      peak <= '0;
    end else if (clk_enable && out_valid) begin
      for (int c = 0; c < CHANNELS; c++)
        if (mag[c] > peak[c*WIDTH +: WIDTH]) peak[c*WIDTH +: WIDTH] <= mag[c];
    end
  end
`endif

endmodule

// File: tb/tb_noise_generator_mc.sv
// Randomised bench for noise_generator_mc against a window-sum reference model; covers NOISE_PEAK_EN when defined.
module tb_noise_generator_mc;
  localparam int W = 16, CH = 2, T = 4;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, ld = 1'b0, mode = 1'b0;
  logic [31:0] seed = '0;
  logic [3:0] atten = '0;
  logic [CH*W-1:0] out;
  logic out_valid;
`ifdef NOISE_PEAK_EN
  logic pclr = 1'b0;
  logic [CH*W-1:0] peak;
`endif

  noise_generator_mc dut (
    .clk(clk), .reset(rst), .clk_enable(en), .load(ld), .seed_in(seed),
    .mode(mode), .atten(atten),
`ifdef NOISE_PEAK_EN
    .peak_clr(pclr), .peak(peak),
`endif
    .out(out), .out_valid(out_valid));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference: each channel keeps the literal list of its last T samples and sums it on demand.
  bit [31:0] m_lfsr [CH];
  int        m_hist [CH][$];
  logic [W-1:0] m_out [CH];
  int        m_edges;
  bit        m_valid;
  logic [W-1:0] m_peak [CH];

  function automatic bit [31:0] derive(input bit [31:0] s, input int c);
    bit [31:0] d = s ^ (32'(c) * 32'h9E37_79B9);
    return (d == 0) ? 32'h1 : d;
  endfunction

  task automatic model_seed(input bit [31:0] s);
    for (int c = 0; c < CH; c++) begin
      m_lfsr[c] = derive(s, c);
      m_hist[c] = {};
    end
    m_edges = 0;
    m_valid = 0;
    for (int c = 0; c < CH; c++) m_peak[c] = '0;
  endtask

  task automatic model_reset();
    model_seed(SEED);
    for (int c = 0; c < CH; c++) m_out[c] = '0;
  endtask

  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] v);
    int x = int'($signed(v));
    if (x < 0) x = -x;
    if (x > 32767) x = 32767;
    return W'(x);
  endfunction

  task automatic model_edge();
    int u, sum;
`ifdef NOISE_PEAK_EN
    for (int c = 0; c < CH; c++)
      if (pclr || ld) m_peak[c] = '0;
      else if (en && m_valid && abs_sat(m_out[c]) > m_peak[c]) m_peak[c] = abs_sat(m_out[c]);
`endif
    if (ld) begin
      logic [W-1:0] keep [CH];
      keep = m_out;
      model_seed(seed);
      m_out = keep;
`ifdef NOISE_PEAK_EN
      for (int c = 0; c < CH; c++) m_peak[c] = '0;
`endif
    end else if (en) begin
      for (int c = 0; c < CH; c++) begin
        u = int'($signed(m_lfsr[c][31:16]));
        sum = 0;
        foreach (m_hist[c][k]) sum += m_hist[c][k];
        m_out[c] = mode ? W'(u >>> atten) : W'(sum >>> (2 + int'(atten)));
        m_hist[c].push_back(u);
        if (m_hist[c].size() > T) void'(m_hist[c].pop_front());
        m_lfsr[c] = (m_lfsr[c] >> 1) ^ (m_lfsr[c][0] ? 32'h8020_0003 : 32'h0);
      end
      m_edges++;
      m_valid = (m_edges >= T + 1);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("out_ch%0d", c), 64'(out[c*W +: W]), 64'(m_out[c]));
      chk($sformatf("lfsr_ch%0d", c), 64'(dut.lfsr[c]), 64'(m_lfsr[c]));
`ifdef NOISE_PEAK_EN
      chk($sformatf("peak_ch%0d", c), 64'(peak[c*W +: W]), 64'(m_peak[c]));
`endif
    end
    chk("out_valid", 64'(out_valid), 64'(m_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    chk("async_rst_out", 64'(out), 64'h0);
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    model_reset();
    #1 rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_out", 64'(out), 64'h0);
    chk("reset_valid", 64'(out_valid), 64'h0);
    compare_all();
    rst = 1'b1;

    // Literal pins: uniform mode exposes the seed top bits, then one Galois step.
    en = 1; mode = 1; atten = 0;
    tick();
    chk("pin_s0_ch0", 64'(out[15:0]), 64'hACE1);
    chk("pin_s0_ch1", 64'(out[31:16]), 64'h32D6);
    tick();
    chk("pin_s1_ch0", 64'(out[15:0]), 64'h5670);
    chk("pin_s1_ch1", 64'(out[31:16]), 64'h994B);
    reset_pulse();

    mode = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 4) chk("valid_after_4", 64'(out_valid), 64'h0);
      if (i == 5) chk("valid_after_5", 64'(out_valid), 64'h1);
    end

    en = 0;
    repeat (10) tick();
    en = 1;
    repeat (20) tick();

    en = 0; ld = 1; seed = SEED;
    tick();
    chk("load_valid", 64'(out_valid), 64'h0);
    ld = 0; en = 1;
    repeat (30) tick();

    ld = 1; seed = 32'h0;
    tick();
    chk("seed0_ch0", 64'(dut.lfsr[0]), 64'h1);
    chk("seed0_ch1_nz", 64'(dut.lfsr[1] != 0), 64'h1);
    ld = 0;
    for (int i = 0; i < 1000; i++) begin
      mode = 1'($urandom_range(0, 1));
      atten = 4'($urandom_range(0, 15));
      tick();
    end
    for (int c = 0; c < CH; c++) chk("no_lockup", 64'(dut.lfsr[c] != 0), 64'h1);

    mode = 0; atten = 15;
    repeat (20) begin
      tick();
      for (int c = 0; c < CH; c++)
        chk("atten15", 64'(out[c*W +: W] == 16'h0 || out[c*W +: W] == 16'hFFFF), 64'h1);
    end

    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      ld    = ($urandom_range(0, 49) == 0);
      seed  = $urandom;
      mode  = 1'($urandom_range(0, 1));
      atten = 4'($urandom_range(0, 15));
`ifdef NOISE_PEAK_EN
      pclr  = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    ld = 0; en = 1;
`ifdef NOISE_PEAK_EN
    pclr = 1;
    tick();
    chk("peak_clr", 64'(peak), 64'h0);
    pclr = 0;
`endif
    repeat (12) tick();
    reset_pulse();
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
